// File: rtl/fp_add_driver.sv
// Initiator side of the adder stb/ack protocol: accepts an operand pair, presents A then B,
// collects Z into a one-entry result slot, with a per-phase watchdog and a transaction counter.
module fp_add_driver #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] input_a,
    output logic             input_a_stb,
    input  logic             input_a_ack,
    output logic [WIDTH-1:0] input_b,
    output logic             input_b_stb,
    input  logic             input_b_ack,
    input  logic [WIDTH-1:0] output_z,
    input  logic             output_z_stb,
    output logic             output_z_ack,
    output logic [WIDTH-1:0] res_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_timeout,
    output logic             err,
    output logic [CNT_W-1:0] txn_count,
    output logic             busy
);

    localparam int unsigned    WD_W = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_WAIT_Z = 3'd3,
        S_ACK_Z  = 3'd4,
        S_ABORT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [WIDTH-1:0] input_a_q, input_a_d;
    logic [WIDTH-1:0] input_b_q, input_b_d;
    logic [WIDTH-1:0] res_z_q, res_z_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;
    logic             op_ready_q, op_ready_d;
    logic             input_a_stb_q, input_a_stb_d;
    logic             input_b_stb_q, input_b_stb_d;
    logic             output_z_ack_q, output_z_ack_d;
    logic             res_valid_q, res_valid_d;
    logic             res_timeout_q, res_timeout_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             slot_free;
    logic             wd_tick;
    logic             wd_expired;
    logic             load_nan;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            wd_q           <= '0;
            input_a_q      <= '0;
            input_b_q      <= '0;
            res_z_q        <= '0;
            txn_count_q    <= '0;
            op_ready_q     <= 1'b0;
            input_a_stb_q  <= 1'b0;
            input_b_stb_q  <= 1'b0;
            output_z_ack_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_timeout_q  <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            input_a_q      <= input_a_d;
            input_b_q      <= input_b_d;
            res_z_q        <= res_z_d;
            txn_count_q    <= txn_count_d;
            op_ready_q     <= op_ready_d;
            input_a_stb_q  <= input_a_stb_d;
            input_b_stb_q  <= input_b_stb_d;
            output_z_ack_q <= output_z_ack_d;
            res_valid_q    <= res_valid_d;
            res_timeout_q  <= res_timeout_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    // Next state, watchdog and result slot
    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        input_a_d     = input_a_q;
        input_b_d     = input_b_q;
        res_z_d       = res_z_q;
        res_valid_d   = res_valid_q;
        res_timeout_d = res_timeout_q;
        err_d         = err_q;
        txn_count_d   = txn_count_q;
        wd_tick       = 1'b0;
        load_nan      = 1'b0;

        slot_free  = !res_valid_q || res_ready;
        wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready_q) begin
                    input_a_d = op_a;
                    input_b_d = op_b;
                    wd_d      = '0;
                    state_d   = S_SEND_A;
                end
            end
            S_SEND_A: begin
                if (input_a_stb_q && input_a_ack) begin
                    wd_d    = '0;
                    state_d = S_SEND_B;
                end else begin
                    wd_tick = 1'b1;
                end
            end
            S_SEND_B: begin
                if (input_b_stb_q && input_b_ack) begin
                    wd_d    = '0;
                    state_d = S_WAIT_Z;
                end else begin
                    wd_tick = 1'b1;
                end
            end
            S_WAIT_Z: begin
                // A result held off by an occupied slot freezes the watchdog
                if (output_z_stb) begin
                    if (slot_free) begin
                        res_z_d       = output_z;
                        res_valid_d   = 1'b1;
                        res_timeout_d = 1'b0;
                        txn_count_d   = txn_count_q + CNT_W'(1);
                        state_d       = S_ACK_Z;
                    end
                end else begin
                    wd_tick = 1'b1;
                end
            end
            S_ACK_Z: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                if (slot_free) begin
                    load_nan = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wd_tick) begin
            if (wd_expired) begin
                err_d = 1'b1;
                if (slot_free) begin
                    load_nan = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_ABORT;
                end
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end

        if (load_nan) begin
            res_z_d       = QNAN;
            res_valid_d   = 1'b1;
            res_timeout_d = 1'b1;
        end

        op_ready_d     = (state_d == S_IDLE);
        input_a_stb_d  = (state_d == S_SEND_A);
        input_b_stb_d  = (state_d == S_SEND_B);
        output_z_ack_d = (state_d == S_ACK_Z);
        busy_d         = (state_d != S_IDLE);
    end

    assign op_ready     = op_ready_q;
    assign input_a      = input_a_q;
    assign input_a_stb  = input_a_stb_q;
    assign input_b      = input_b_q;
    assign input_b_stb  = input_b_stb_q;
    assign output_z_ack = output_z_ack_q;
    assign res_z        = res_z_q;
    assign res_valid    = res_valid_q;
    assign res_timeout  = res_timeout_q;
    assign err          = err_q;
    assign txn_count    = txn_count_q;
    assign busy         = busy_q;

endmodule
